// File: rtl/floppy_pkg.sv
// Shared types and defaults for the floppy-drive stepper: state encoding, track range,
// homing timing and the period width used by the step timer.
package floppy_pkg;

   localparam int unsigned PeriodW           = 16;
   localparam int unsigned TrackW            = 7;
   localparam int unsigned HomeCntW          = 16;
   localparam int unsigned MaxTrackDefault   = 79;
   localparam int unsigned HomePeriodDefault = 196;
   localparam int unsigned HomeStepsDefault  = 80;

   typedef enum logic [1:0] {
      StInit,
      StHome,
      StRun
   } floppy_state_e;

   // A period of 1 would keep STEP permanently low, so it is stretched to 2.
   function automatic logic [PeriodW-1:0] eff_period(input logic [PeriodW-1:0] p);
      return (p == PeriodW'(1)) ? PeriodW'(2) : p;
   endfunction

endpackage

// File: rtl/floppy_step_timer.sv
// Period counter that emits a registered single-cycle active-low STEP pulse every
// `period` cycles; a zero period holds the counter idle.
module floppy_step_timer
   import floppy_pkg::*;
(
   input  logic               clock_98k,
   input  logic               reset,
   input  logic               enable,
   input  logic               clear,
   input  logic [PeriodW-1:0] period,
   output logic               step_n
);

   logic [PeriodW-1:0] cnt_q;
   logic               fire;

   // Compare against the live period so a shortened period takes effect at once.
   assign fire = (cnt_q >= (period - PeriodW'(1)));

   always_ff @(posedge clock_98k or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         step_n <= 1'b1;
      end else if (clear || !enable || (period == '0)) begin
         cnt_q  <= '0;
         step_n <= 1'b1;
      end else if (fire) begin
         cnt_q  <= '0;
         step_n <= 1'b0;
      end else begin
         cnt_q  <= cnt_q + PeriodW'(1);
         step_n <= 1'b1;
      end
   end

endmodule

// File: rtl/floppy_drive.sv
// Floppy-drive stepper: homes the head toward track 0, then sweeps it back and forth
// across the tracks, stepping at the note period supplied by the controller.
module floppy_drive
   import floppy_pkg::*;
#(
   parameter int unsigned HOME_PERIOD = HomePeriodDefault,
   parameter int unsigned HOME_STEPS  = HomeStepsDefault,
   parameter int unsigned MAX_TRACK   = MaxTrackDefault
) (
   input  logic               clock_98k,
   input  logic               reset,
   input  logic [PeriodW-1:0] period_in,
   output logic               step_n,
   output logic               dir,
   output logic               drive_sel_n,
   output logic [TrackW-1:0]  track_pos,
   output logic               homed
);

   floppy_state_e        state_q;
   logic [HomeCntW-1:0]  home_cnt_q;
   logic [PeriodW-1:0]   timer_period;
   logic                 timer_en;
   logic                 home_done;
   logic [TrackW-1:0]    next_track;

   always_comb begin
      timer_period = (state_q == StHome) ? PeriodW'(HOME_PERIOD) : eff_period(period_in);
      timer_en     = (state_q != StInit);
      // The last homing pulse has just been issued; switch to RUN as STEP returns high.
      home_done    = (state_q == StHome) && !step_n &&
                     (home_cnt_q == HomeCntW'(HOME_STEPS - 1));
      next_track   = dir ? (track_pos + TrackW'(1)) : (track_pos - TrackW'(1));
   end

   floppy_step_timer u_step_timer (
      .clock_98k (clock_98k),
      .reset     (reset),
      .enable    (timer_en),
      .clear     (home_done),
      .period    (timer_period),
      .step_n    (step_n)
   );

   always_ff @(posedge clock_98k or negedge reset) begin
      if (!reset) begin
         state_q     <= StInit;
         home_cnt_q  <= '0;
         dir         <= 1'b0;
         drive_sel_n <= 1'b1;
         track_pos   <= '0;
         homed       <= 1'b0;
      end else begin
         case (state_q)
            StInit: begin
               state_q     <= StHome;
               drive_sel_n <= 1'b0;
            end
            StHome: begin
               if (home_done) begin
                  state_q    <= StRun;
                  home_cnt_q <= '0;
                  track_pos  <= '0;
                  dir        <= 1'b1;
                  homed      <= 1'b1;
               end else if (!step_n) begin
                  home_cnt_q <= home_cnt_q + HomeCntW'(1);
               end
            end
            StRun: begin
               // Track and direction follow the pulse by one cycle, never during it.
               if (!step_n) begin
                  track_pos <= next_track;
                  if (dir && (next_track == TrackW'(MAX_TRACK))) begin
                     dir <= 1'b0;
                  end else if (!dir && (next_track == '0)) begin
                     dir <= 1'b1;
                  end
               end
            end
            default: state_q <= StInit;
         endcase
      end
   end

endmodule

// File: tb/tb_floppy_drive.sv
// Directed bench for floppy_drive: expected STEP pulses (cycle, track, dir) are queued
// as stimulus is applied and matched against the pulses the drive produces.
module tb_floppy_drive;

   logic        clock_98k = 1'b0;
   logic        reset;
   logic [15:0] period_in;
   logic        step_n;
   logic        dir;
   logic        drive_sel_n;
   logic [6:0]  track_pos;
   logic        homed;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int   cyc;
      int   trk;
      logic d;
   } pulse_t;

   pulse_t exp_q[$];
   int     m_trk;
   logic   m_dir;

   floppy_drive #(
      .HOME_PERIOD (4),
      .HOME_STEPS  (80),
      .MAX_TRACK   (79)
   ) dut (
      .clock_98k   (clock_98k),
      .reset       (reset),
      .period_in   (period_in),
      .step_n      (step_n),
      .dir         (dir),
      .drive_sel_n (drive_sel_n),
      .track_pos   (track_pos),
      .homed       (homed)
   );

   always #5 clock_98k = ~clock_98k;

   always @(posedge clock_98k) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Scoreboard side: every observed pulse must match the head of the queue.
   always @(negedge clock_98k) begin
      if (reset === 1'b1 && step_n === 1'b0) begin
         pulse_t p;
         check("pulse_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            p = exp_q.pop_front();
            check("pulse_cycle", cyc, p.cyc);
            check("pulse_track", 32'(track_pos), p.trk);
            check("pulse_dir", 32'(dir), 32'(p.d));
         end
      end
   end

   task automatic step_cycle();
      @(posedge clock_98k);
      #1;
   endtask

   task automatic push_home(input int start);
      for (int k = 1; k <= 80; k++) exp_q.push_back('{start + 4 * k, 0, 1'b0});
   endtask

   // Queue RUN pulses and advance the head-position model past each of them.
   task automatic push_pulses(input int first, input int per, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{first + i * per, m_trk, m_dir});
         if (m_dir) begin
            m_trk++;
            if (m_trk == 79) m_dir = 1'b0;
         end else begin
            m_trk--;
            if (m_trk == 0) m_dir = 1'b1;
         end
      end
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clock_98k);
         #1;
         n++;
      end
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   // One idle cycle zeroes the tick counter; the new period is applied at `start`.
   task automatic idle_then(input logic [15:0] p, output int start);
      period_in = '0;
      step_cycle();
      period_in = p;
      start = cyc;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      int n;
      reset     = 1'b0;
      period_in = '0;
      m_trk     = 0;
      m_dir     = 1'b0;
      repeat (5) @(posedge clock_98k);
      #1;
      check("rst_step_n", 32'(step_n), 1);
      check("rst_dir", 32'(dir), 0);
      check("rst_drive_sel_n", 32'(drive_sel_n), 1);
      check("rst_track_pos", 32'(track_pos), 0);
      check("rst_homed", 32'(homed), 0);

      // Homing: 80 pulses, 4 cycles apart, dir low
      reset = 1'b1;
      c = cyc;
      push_home(c + 1);
      repeat (10) step_cycle();
      check("home_drive_sel_n", 32'(drive_sel_n), 0);
      check("home_homed", 32'(homed), 0);
      check("home_track_pos", 32'(track_pos), 0);
      drain(400);
      step_cycle();
      check("homed_after", 32'(homed), 1);
      check("homed_track", 32'(track_pos), 0);
      check("homed_dir", 32'(dir), 1);
      m_trk = 0;
      m_dir = 1'b1;

      // Period 223 straight after homing
      period_in = 16'd223;
      c = cyc;
      push_pulses(c + 223, 223, 3);
      drain(700);
      step_cycle();
      check("p223_track", 32'(track_pos), 32'(m_trk));

      // Period 2: full sweep up to 79 and back down past 0
      idle_then(16'd2, c);
      push_pulses(c + 2, 2, 157);
      drain(400);
      step_cycle();
      check("sweep_track", 32'(track_pos), 32'(m_trk));
      check("sweep_dir", 32'(dir), 32'(m_dir));

      // Period 300 -> 0 at counter 150, then back to 300
      idle_then(16'd300, c);
      repeat (150) step_cycle();
      period_in = '0;
      repeat (400) step_cycle();
      check("silence_track", 32'(track_pos), 32'(m_trk));
      check("silence_step_n", 32'(step_n), 1);
      period_in = 16'd300;
      c = cyc;
      push_pulses(c + 300, 300, 1);
      drain(320);
      step_cycle();

      // Period 500 -> 100 at counter 250 fires next cycle
      idle_then(16'd500, c);
      repeat (250) step_cycle();
      period_in = 16'd100;
      c = cyc;
      push_pulses(c + 1, 100, 3);
      drain(400);
      step_cycle();

      // Period 1 behaves as 2
      idle_then(16'd1, c);
      push_pulses(c + 2, 2, 4);
      drain(20);
      step_cycle();
      check("p1_track", 32'(track_pos), 32'(m_trk));

      // Run to track 40, reset in the middle of its pulse
      idle_then(16'd2, c);
      n = 0;
      while (m_trk != 40) begin
         push_pulses(c + 2 + 2 * n, 2, 1);
         n++;
      end
      push_pulses(c + 2 + 2 * n, 2, 1);
      drain(400);
      check("pre_rst_step_n", 32'(step_n), 0);
      check("pre_rst_track", 32'(track_pos), 40);
      reset = 1'b0;
      #1;
      check("mid_rst_step_n", 32'(step_n), 1);
      check("mid_rst_track", 32'(track_pos), 0);
      check("mid_rst_homed", 32'(homed), 0);
      check("mid_rst_drive_sel_n", 32'(drive_sel_n), 1);
      check("mid_rst_dir", 32'(dir), 0);
      repeat (3) @(posedge clock_98k);
      #1;

      // Full homing again; period_in stays at 2 and must be ignored
      reset = 1'b1;
      c = cyc;
      push_home(c + 1);
      drain(400);
      step_cycle();
      period_in = '0;
      check("rehomed", 32'(homed), 1);
      check("rehomed_track", 32'(track_pos), 0);
      check("rehomed_dir", 32'(dir), 1);
      repeat (20) step_cycle();
      check("final_track", 32'(track_pos), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
